// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one single-ported, variable-latency memory bus
// between instruction fetch and the data (load/store) port. Only one bus
// transaction is in flight at a time. Data normally wins over fetch.
// Optional build macro MEM_ARB_FAIRNESS_EN: once MAX_DATA_BURST data grants in
// a row have been made while fetch was waiting, fetch wins the next contested
// arbitration.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | bus free; arbitrate between inst_req and data_req
// BUSY_I | fetch transaction on the bus, waiting for bus_ack
// BUSY_D | load/store transaction on the bus, waiting for bus_ack
module pipeline_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_ready,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_ready,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack,
  output logic                    want_stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  logic   grant_d;
  logic   grant_i;
  logic   fetch_turn;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);

  logic [CNT_W-1:0] burst_cnt;

  assign fetch_turn = (burst_cnt >= CNT_W'(MAX_DATA_BURST));

  // Count consecutive data grants that left fetch waiting; saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (!inst_req || grant_i) begin
        burst_cnt <= '0;
      end else if (grant_d && (burst_cnt < CNT_W'(MAX_DATA_BURST))) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end
  end
`else
  // Strict data priority: the burst limit has no effect in this build.
  assign fetch_turn = 1'b0;

  // A burst limit below one is meaningless; nothing is built either way.
  if (MAX_DATA_BURST < 1) begin : g_burst_unused
  end
`endif

  // Arbitration in IDLE: data first unless fetch has earned its turn.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (data_req && !(inst_req && fetch_turn)) begin
        grant_d = 1'b1;
      end else if (inst_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Transaction sequencer: latch the winner onto the bus, hold until bus_ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            bus_req   <= 1'b1;
            bus_we    <= data_we;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            bus_be    <= data_be;
          end else if (grant_i) begin
            state     <= BUSY_I;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
            bus_be    <= '1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // A flushed fetch (inst_req dropped) still finishes on the bus but gets no pulse.
  assign data_ready = bus_ack && (state == BUSY_D);
  assign inst_ready = bus_ack && (state == BUSY_I) && inst_req;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign want_stall = (inst_req && !inst_ready) || (data_req && !data_ready);

  // The data port must hold its request for the whole transaction.
  a_data_req_held: assert property (@(posedge clock) disable iff (!reset_n)
                                    (state == BUSY_D) |-> data_req);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level arbitration model.
module tb_pipeline_mem_arbiter;

  localparam int MAXB = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        want_stall;

  pipeline_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(MAXB)) dut (
    .clock(clock), .reset_n(reset_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_rdata(data_rdata), .data_ready(data_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .want_stall(want_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  be;
    bit          snap_d;
    bit          snap_i;
    bit          i_low;
    bit          unstable;
  } grant_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } req_t;

  grant_t glog[$];
  req_t   dq[$];
  req_t   iq[$];

  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  bit          rand_rdata = 1'b0;
  bit          spurious_ack = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  logic [31:0] mem_last_rdata = 32'h0;
  bit          snap_d = 1'b0;
  bit          snap_i = 1'b0;
  bit          i_low_acc = 1'b1;
  int          n_iready = 0;
  int          n_dready = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Negedge monitor: request snapshot as seen by the next edge, plus pulse counts.
  initial begin
    forever begin
      @(negedge clock);
      snap_d = data_req;
      snap_i = inst_req;
      if (!reset_n || (!bus_req && !inst_req)) i_low_acc = 1'b1;
      if (inst_ready) n_iready++;
      if (data_ready) n_dready++;
    end
  end

  // Memory model: acks each transaction after a latency, logs what was granted.
  initial begin
    bit     in_txn;
    int     cnt;
    grant_t cur;
    in_txn = 1'b0;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      bus_ack = 1'b0;
      if (!reset_n) begin
        in_txn = 1'b0;
        continue;
      end
      if (in_txn && !bus_req) in_txn = 1'b0;
      if (!in_txn && !bus_req && spurious_ack) begin
        bus_ack = 1'b1;
        bus_rdata = 32'h5A5A_A5A5;
      end
      if (!in_txn && bus_req) begin
        in_txn = 1'b1;
        cur.addr = bus_addr;
        cur.wdata = bus_wdata;
        cur.we = bus_we;
        cur.be = bus_be;
        cur.snap_d = snap_d;
        cur.snap_i = snap_i;
        cur.i_low = i_low_acc;
        cur.unstable = 1'b0;
        i_low_acc = 1'b0;
        cnt = rand_lat ? $urandom_range(1, 4) : mem_lat;
      end
      if (in_txn) begin
        if (bus_addr !== cur.addr || bus_wdata !== cur.wdata || bus_we !== cur.we ||
            bus_be !== cur.be || bus_req !== 1'b1) cur.unstable = 1'b1;
        cnt--;
        if (cnt <= 0) begin
          bus_ack = 1'b1;
          bus_rdata = rand_rdata ? $urandom : fixed_rdata;
          mem_last_rdata = bus_rdata;
          cur.rdata = bus_rdata;
          glog.push_back(cur);
          in_txn = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_be = 4'h0;
    repeat (3) @(negedge clock);
    vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    vectors++; if (bus_we !== 1'b0) begin miscompares++; $display("FAIL reset_bus_we got=%b exp=0", bus_we); end
    vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
    vectors++; if (bus_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); end
    vectors++; if (bus_be !== 4'h0) begin miscompares++; $display("FAIL reset_bus_be got=%h exp=0", bus_be); end
    vectors++; if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got=%b%b exp=00", inst_ready, data_ready); end
    vectors++; if (want_stall !== 1'b0) begin miscompares++; $display("FAIL reset_want_stall got=%b exp=0", want_stall); end
    reset_n = 1'b1;
    // A stray ack while idle must produce nothing.
    @(posedge clock); #1; spurious_ack = 1'b1;
    @(negedge clock);
    vectors++; if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin
      miscompares++; $display("FAIL idle_ack_ready got=%b%b exp=00", inst_ready, data_ready); end
    @(posedge clock); #1; spurious_ack = 1'b0;
    @(negedge clock);
    vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL idle_ack_bus_req got=%b exp=0", bus_req); end
    glog.delete();
  endtask

  task automatic test_single_fetch();
    logic exp_req, exp_rdy, exp_st;
    mem_lat = 2; rand_lat = 1'b0; rand_rdata = 1'b0; fixed_rdata = 32'hDEADBEEF;
    @(posedge clock); #1; inst_req = 1'b1; inst_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      exp_req = (k == 1 || k == 2); exp_rdy = (k == 2); exp_st = (k < 2);
      vectors++; if (bus_req !== exp_req) begin miscompares++; $display("FAIL fetch_bus_req k=%0d got=%b exp=%b", k, bus_req, exp_req); end
      vectors++; if (inst_ready !== exp_rdy) begin miscompares++; $display("FAIL fetch_inst_ready k=%0d got=%b exp=%b", k, inst_ready, exp_rdy); end
      vectors++; if (want_stall !== exp_st) begin miscompares++; $display("FAIL fetch_want_stall k=%0d got=%b exp=%b", k, want_stall, exp_st); end
      vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_data_ready k=%0d got=%b exp=0", k, data_ready); end
      if (exp_req) begin
        vectors++; if (bus_addr !== 32'h100 || bus_be !== 4'hF || bus_we !== 1'b0) begin
          miscompares++; $display("FAIL fetch_bus_fields k=%0d got=%h/%h/%b exp=100/f/0", k, bus_addr, bus_be, bus_we); end
      end
      if (exp_rdy) begin
        vectors++; if (inst_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_rdata got=%h exp=deadbeef", inst_rdata); end
      end
      @(posedge clock); #1;
      if (k == 2) inst_req = 1'b0;
    end
  endtask

  task automatic test_store();
    logic exp_req, exp_rdy;
    mem_lat = 3; fixed_rdata = 32'h0;
    @(posedge clock); #1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2000; data_wdata = 32'h12345678; data_be = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      exp_req = (k >= 1 && k <= 3); exp_rdy = (k == 3);
      vectors++; if (bus_req !== exp_req) begin miscompares++; $display("FAIL store_bus_req k=%0d got=%b exp=%b", k, bus_req, exp_req); end
      vectors++; if (data_ready !== exp_rdy) begin miscompares++; $display("FAIL store_data_ready k=%0d got=%b exp=%b", k, data_ready, exp_rdy); end
      vectors++; if (inst_ready !== 1'b0) begin miscompares++; $display("FAIL store_inst_ready k=%0d got=%b exp=0", k, inst_ready); end
      if (exp_req) begin
        vectors++; if (bus_we !== 1'b1 || bus_be !== 4'b0011 || bus_addr !== 32'h2000 || bus_wdata !== 32'h12345678) begin
          miscompares++; $display("FAIL store_bus_fields k=%0d got=%b/%h/%h/%h exp=1/3/2000/12345678", k, bus_we, bus_be, bus_addr, bus_wdata); end
      end
      @(posedge clock); #1;
      if (k == 3) data_req = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic exp_req, exp_d, exp_i, exp_st;
    mem_lat = 1; fixed_rdata = 32'hA0A0_0001;
    @(posedge clock); #1;
    inst_req = 1'b1; inst_addr = 32'h180;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2040; data_wdata = 32'h0; data_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      exp_req = (k == 1 || k == 3); exp_d = (k == 1); exp_i = (k == 3); exp_st = (k <= 2);
      vectors++; if (bus_req !== exp_req) begin miscompares++; $display("FAIL contend_bus_req k=%0d got=%b exp=%b", k, bus_req, exp_req); end
      vectors++; if (data_ready !== exp_d) begin miscompares++; $display("FAIL contend_data_ready k=%0d got=%b exp=%b", k, data_ready, exp_d); end
      vectors++; if (inst_ready !== exp_i) begin miscompares++; $display("FAIL contend_inst_ready k=%0d got=%b exp=%b", k, inst_ready, exp_i); end
      vectors++; if (want_stall !== exp_st) begin miscompares++; $display("FAIL contend_want_stall k=%0d got=%b exp=%b", k, want_stall, exp_st); end
      if (k == 1) begin
        vectors++; if (bus_addr !== 32'h2040) begin miscompares++; $display("FAIL contend_first_addr got=%h exp=2040", bus_addr); end
      end
      if (k == 3) begin
        vectors++; if (bus_addr !== 32'h180) begin miscompares++; $display("FAIL contend_second_addr got=%h exp=180", bus_addr); end
      end
      @(posedge clock); #1;
      if (k == 1) data_req = 1'b0;
      if (k == 3) inst_req = 1'b0;
    end
  endtask

  task automatic test_flush();
    logic exp_req, exp_rdy, exp_st;
    int   g0;
    mem_lat = 3; fixed_rdata = 32'hCAFE0001;
    g0 = glog.size();
    @(posedge clock); #1; inst_req = 1'b1; inst_addr = 32'h300;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      exp_req = (k >= 1 && k <= 3) || (k >= 5 && k <= 7);
      exp_rdy = (k == 7);
      exp_st  = (k <= 1) || (k >= 4 && k <= 6);
      vectors++; if (bus_req !== exp_req) begin miscompares++; $display("FAIL flush_bus_req k=%0d got=%b exp=%b", k, bus_req, exp_req); end
      vectors++; if (inst_ready !== exp_rdy) begin miscompares++; $display("FAIL flush_inst_ready k=%0d got=%b exp=%b", k, inst_ready, exp_rdy); end
      vectors++; if (want_stall !== exp_st) begin miscompares++; $display("FAIL flush_want_stall k=%0d got=%b exp=%b", k, want_stall, exp_st); end
      if (k >= 5 && k <= 7) begin
        vectors++; if (bus_addr !== 32'h340) begin miscompares++; $display("FAIL flush_refetch_addr k=%0d got=%h exp=340", k, bus_addr); end
      end
      if (exp_rdy) begin
        vectors++; if (inst_rdata !== 32'hCAFE0001) begin miscompares++; $display("FAIL flush_refetch_rdata got=%h exp=cafe0001", inst_rdata); end
      end
      @(posedge clock); #1;
      if (k == 1) inst_req = 1'b0;
      if (k == 3) begin inst_req = 1'b1; inst_addr = 32'h340; end
      if (k == 7) inst_req = 1'b0;
    end
    vectors++; if (glog.size() - g0 != 2) begin miscompares++; $display("FAIL flush_bus_txns got=%0d exp=2", glog.size() - g0); end
  endtask

  task automatic test_async_reset();
    int  d0;
    bit  got;
    d0 = n_dready;
    mem_lat = 5; fixed_rdata = 32'h0BAD_F00D;
    @(posedge clock); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h4000; data_wdata = 32'h0; data_be = 4'hF;
    repeat (2) @(negedge clock);
    vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL arst_granted got=%b exp=1", bus_req); end
    @(negedge clock);
    #2; reset_n = 1'b0;
    #1;
    vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL arst_bus_req_async got=%b exp=0", bus_req); end
    vectors++; if (bus_addr !== 32'h0 || bus_be !== 4'h0) begin
      miscompares++; $display("FAIL arst_bus_fields got=%h/%h exp=0/0", bus_addr, bus_be); end
    @(posedge clock);
    @(negedge clock);
    vectors++; if (data_ready !== 1'b0 || bus_req !== 1'b0) begin
      miscompares++; $display("FAIL arst_in_reset got=%b/%b exp=0/0", data_ready, bus_req); end
    reset_n = 1'b1;
    @(negedge clock);
    vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h4000) begin
      miscompares++; $display("FAIL arst_regrant got=%b/%h exp=1/4000", bus_req, bus_addr); end
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      if (data_ready) begin
        got = 1'b1;
        vectors++; if (data_rdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL arst_rdata got=%h exp=0badf00d", data_rdata); end
      end
    end
    if (!got) begin vectors++; miscompares++; $display("FAIL arst_ready_timeout got=none exp=pulse"); end
    @(posedge clock); #1; data_req = 1'b0;
    @(negedge clock);
    vectors++; if (n_dready - d0 != 1) begin miscompares++; $display("FAIL arst_ready_count got=%0d exp=1", n_dready - d0); end
  endtask

  task automatic data_client(input int n);
    for (int i = 0; i < n; i++) begin
      int   gap;
      bit   got;
      req_t r;
      gap = $urandom_range(0, 3);
      got = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      r.addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      r.wdata = $urandom;
      r.we    = 1'($urandom_range(0, 1));
      r.be    = 4'($urandom_range(1, 15));
      data_addr = r.addr; data_wdata = r.wdata; data_we = r.we; data_be = r.be; data_req = 1'b1;
      dq.push_back(r);
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clock);
        if (data_ready) begin
          got = 1'b1;
          vectors++; if (data_rdata !== mem_last_rdata) begin
            miscompares++; $display("FAIL rand_data_rdata got=%h exp=%h", data_rdata, mem_last_rdata); end
        end
      end
      if (!got) begin vectors++; miscompares++; $display("FAIL rand_data_timeout req=%0d got=none exp=pulse", i); end
      @(posedge clock); #1; data_req = 1'b0;
    end
  endtask

  task automatic fetch_client(input int n);
    for (int i = 0; i < n; i++) begin
      int   gap;
      bit   got;
      req_t r;
      gap = $urandom_range(0, 3);
      got = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      r.addr = $urandom & 32'h0000_FFFC;
      r.wdata = 32'h0; r.we = 1'b0; r.be = 4'hF;
      inst_addr = r.addr; inst_req = 1'b1;
      iq.push_back(r);
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clock);
        if (inst_ready) begin
          got = 1'b1;
          vectors++; if (inst_rdata !== mem_last_rdata) begin
            miscompares++; $display("FAIL rand_inst_rdata got=%h exp=%h", inst_rdata, mem_last_rdata); end
        end
      end
      if (!got) begin vectors++; miscompares++; $display("FAIL rand_inst_timeout req=%0d got=none exp=pulse", i); end
      @(posedge clock); #1; inst_req = 1'b0;
    end
  endtask

  task automatic test_random_traffic();
    int   cnt;
    bit   exp_fetch;
    bit   act_fetch;
    req_t r;
    int   i0;
    int   d0;
    glog.delete(); dq.delete(); iq.delete();
    rand_lat = 1'b1; rand_rdata = 1'b1;
    i0 = n_iready; d0 = n_dready;
    fork
      data_client(20);
      fetch_client(20);
    join
    repeat (3) @(negedge clock);
    rand_lat = 1'b0; rand_rdata = 1'b0;
    vectors++; if (glog.size() != 40) begin miscompares++; $display("FAIL rand_txn_count got=%0d exp=40", glog.size()); end
    vectors++; if (n_iready - i0 != 20 || n_dready - d0 != 20) begin
      miscompares++; $display("FAIL rand_ready_counts got=%0d/%0d exp=20/20", n_iready - i0, n_dready - d0); end
    // Grant order model: data first; with fairness, fetch after MAXB data grants made over a waiting fetch.
    cnt = 0;
    foreach (glog[i]) begin
      if (glog[i].i_low) cnt = 0;
      exp_fetch = glog[i].snap_i && (!glog[i].snap_d || (FAIR_EN && cnt >= MAXB));
      if (exp_fetch) cnt = 0;
      else if (glog[i].snap_i && cnt < MAXB) cnt++;
      act_fetch = !glog[i].addr[31];
      vectors++; if (act_fetch !== exp_fetch) begin
        miscompares++; $display("FAIL rand_grant_kind txn=%0d got_fetch=%b exp_fetch=%b", i, act_fetch, exp_fetch); end
      vectors++; if (glog[i].unstable) begin miscompares++; $display("FAIL rand_bus_stable txn=%0d got=changed exp=held", i); end
      if (exp_fetch) begin
        if (iq.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rand_fetch_underflow txn=%0d got=grant exp=no_request", i);
        end else begin
          r = iq.pop_front();
          vectors++; if (glog[i].addr !== r.addr || glog[i].we !== 1'b0 || glog[i].be !== 4'hF) begin
            miscompares++; $display("FAIL rand_fetch_fields txn=%0d got=%h/%b/%h exp=%h/0/f", i, glog[i].addr, glog[i].we, glog[i].be, r.addr); end
        end
      end else begin
        if (dq.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rand_data_underflow txn=%0d got=grant exp=no_request", i);
        end else begin
          r = dq.pop_front();
          vectors++; if (glog[i].addr !== r.addr || glog[i].we !== r.we || glog[i].be !== r.be || glog[i].wdata !== r.wdata) begin
            miscompares++; $display("FAIL rand_data_fields txn=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", i,
              glog[i].addr, glog[i].we, glog[i].be, glog[i].wdata, r.addr, r.we, r.be, r.wdata); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit  done;
    bit  exp_fetch;
    bit  act_fetch;
    int  i0;
    glog.delete();
    mem_lat = 1; fixed_rdata = 32'h1111_2222;
    i0 = n_iready;
    @(posedge clock); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8000_0500; data_wdata = 32'h0; data_be = 4'hF;
    inst_req = 1'b1; inst_addr = 32'h500;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clock);
      if ((inst_ready || data_ready) && glog.size() >= 10) done = 1'b1;
    end
    if (!done) begin vectors++; miscompares++; $display("FAIL b2b_timeout got=%0d exp=10 txns", glog.size()); end
    @(posedge clock); #1;
    data_req = 1'b0; inst_req = 1'b0;
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
      exp_fetch = FAIR_EN && (i % 5 == 4);
      act_fetch = !glog[i].addr[31];
      vectors++; if (act_fetch !== exp_fetch) begin
        miscompares++; $display("FAIL b2b_grant_kind txn=%0d got_fetch=%b exp_fetch=%b", i, act_fetch, exp_fetch); end
    end
    if (!FAIR_EN) begin
      vectors++; if (n_iready - i0 != 0) begin miscompares++; $display("FAIL b2b_starved_fetch got=%0d exp=0", n_iready - i0); end
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_flush();
    test_async_reset();
    test_random_traffic();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
